// File: rtl/reg_select_sequencer_pkg.sv
// Shared definitions for the register select/encode unit: the operand-fetch
// sequencer states and the default instruction field layout.
package reg_select_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_STEP_B = 2'd1,
        SEQ_STEP_C = 2'd2,
        SEQ_STEP_A = 2'd3
    } seq_state_e;

    localparam int RA_LSB_DEF = 23;
    localparam int RB_LSB_DEF = 19;
    localparam int RC_LSB_DEF = 15;
    localparam int IMM_W_DEF  = 19;

endpackage

// File: rtl/reg_select_sequencer_onehot_decoder.sv
// Binary index to one-hot decoder with enable.
// Ports: en_i (enable), idx_i (IDX_W index), onehot_o (2^IDX_W one-hot, 0 when disabled).
module onehot_decoder #(
    parameter int IDX_W = 4
) (
    input  logic                  en_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [(1<<IDX_W)-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_select_sequencer.sv
// Register select/encode unit: latched IR, Ra/Rb/Rc decode into registered
// one-hot strobes, sign-extended C constant and an Rb->Rc->Ra fetch sequencer.
// Ports: clock, clear_n (async low); ir_load/instruction load the IR;
// gra/grb/grc + rin/rout/baout drive manual strobes; seq_start/seq_use_imm
// launch the sequence; reg_in/reg_out/ba_zero/c_out/seq_done are registered;
// c_sign_extended is combinational from the IR; seq_busy flags a running sequence.
module reg_select_sequencer
    import reg_select_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int DATA_W   = 32,
    parameter int RA_LSB   = RA_LSB_DEF,
    parameter int RB_LSB   = RB_LSB_DEF,
    parameter int RC_LSB   = RC_LSB_DEF,
    parameter int IMM_W    = IMM_W_DEF
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic                ir_load,
    input  logic [DATA_W-1:0]   instruction,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                rin,
    input  logic                rout,
    input  logic                baout,
    input  logic                seq_start,
    input  logic                seq_use_imm,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic                ba_zero,
    output logic                c_out,
    output logic [DATA_W-1:0]   c_sign_extended,
    output logic                seq_busy,
    output logic                seq_done
);

    seq_state_e state_q, state_d;
    logic use_imm_q, use_imm_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [NUM_REGS-1:0] reg_in_q, reg_out_q;
    logic [NUM_REGS-1:0] reg_in_dec, reg_out_dec;
    logic ba_zero_q, ba_zero_d;
    logic c_out_q, c_out_d;
    logic seq_done_q, seq_done_d;

    logic in_en, out_en;
    logic [IDX_W-1:0] in_idx, out_idx;

    // Manual selects use the held IR; the sequencer uses the next IR so a
    // load coinciding with seq_start feeds the new fields into STEP_B.
    logic [IDX_W-1:0] ra_q, rb_q, rc_q;
    logic [IDX_W-1:0] ra_d, rb_d, rc_d;
    logic [IDX_W-1:0] man_idx;
    logic man_sel;

    assign ra_q = ir_q[RA_LSB +: IDX_W];
    assign rb_q = ir_q[RB_LSB +: IDX_W];
    assign rc_q = ir_q[RC_LSB +: IDX_W];
    assign ra_d = ir_d[RA_LSB +: IDX_W];
    assign rb_d = ir_d[RB_LSB +: IDX_W];
    assign rc_d = ir_d[RC_LSB +: IDX_W];

    // Priority gra > grb > grc so multiple selects never merge.
    always_comb begin
        man_sel = 1'b1;
        man_idx = '0;
        if (gra) begin
            man_idx = ra_q;
        end else if (grb) begin
            man_idx = rb_q;
        end else if (grc) begin
            man_idx = rc_q;
        end else begin
            man_sel = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        use_imm_d = use_imm_q;
        ir_d      = ir_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (ir_load) begin
                    ir_d = instruction;
                end
                if (seq_start) begin
                    state_d   = SEQ_STEP_B;
                    use_imm_d = seq_use_imm;
                end
            end
            SEQ_STEP_B: state_d = SEQ_STEP_C;
            SEQ_STEP_C: state_d = SEQ_STEP_A;
            SEQ_STEP_A: state_d = SEQ_IDLE;
            default:    state_d = SEQ_IDLE;
        endcase
    end

    // Strobes are computed for the state being entered, so each step's
    // strobe is visible in the same cycle the FSM sits in that step.
    always_comb begin
        in_en      = 1'b0;
        out_en     = 1'b0;
        in_idx     = '0;
        out_idx    = '0;
        ba_zero_d  = 1'b0;
        c_out_d    = 1'b0;
        seq_done_d = 1'b0;
        unique case (state_d)
            SEQ_STEP_B: begin
                out_en  = 1'b1;
                out_idx = rb_d;
            end
            SEQ_STEP_C: begin
                if (use_imm_d) begin
                    c_out_d = 1'b1;
                end else begin
                    out_en  = 1'b1;
                    out_idx = rc_d;
                end
            end
            SEQ_STEP_A: begin
                in_en      = 1'b1;
                in_idx     = ra_d;
                seq_done_d = 1'b1;
            end
            default: begin
                // Leaving STEP_A also lands here; manual only from IDLE.
                if (state_q == SEQ_IDLE && man_sel) begin
                    in_idx    = man_idx;
                    out_idx   = man_idx;
                    in_en     = rin;
                    // A write request wins so in/out never collide on the bus.
                    out_en    = !rin &&
                                (rout || (baout && man_idx != '0));
                    ba_zero_d = baout && man_idx == '0;
                end
            end
        endcase
    end

    onehot_decoder #(.IDX_W(IDX_W)) u_dec_in (
        .en_i     (in_en),
        .idx_i    (in_idx),
        .onehot_o (reg_in_dec)
    );

    onehot_decoder #(.IDX_W(IDX_W)) u_dec_out (
        .en_i     (out_en),
        .idx_i    (out_idx),
        .onehot_o (reg_out_dec)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= SEQ_IDLE;
            use_imm_q  <= 1'b0;
            ir_q       <= '0;
            reg_in_q   <= '0;
            reg_out_q  <= '0;
            ba_zero_q  <= 1'b0;
            c_out_q    <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            use_imm_q  <= use_imm_d;
            ir_q       <= ir_d;
            reg_in_q   <= reg_in_dec;
            reg_out_q  <= reg_out_dec;
            ba_zero_q  <= ba_zero_d;
            c_out_q    <= c_out_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign reg_in          = reg_in_q;
    assign reg_out         = reg_out_q;
    assign ba_zero         = ba_zero_q;
    assign c_out           = c_out_q;
    assign seq_done        = seq_done_q;
    assign seq_busy        = (state_q != SEQ_IDLE);
    assign c_sign_extended = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

    // High IR bits carry opcode fields decoded elsewhere.
    logic unused_ir;
    assign unused_ir = ^ir_q;

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Directed bench for reg_select_sequencer: manual select table plus
// hand-written sequencer, immediate, back-to-back and reset cases.
module tb_reg_select_sequencer;

    logic        clock;
    logic        clear_n;
    logic        ir_load;
    logic [31:0] instruction;
    logic        gra, grb, grc, rin, rout, baout;
    logic        seq_start, seq_use_imm;
    logic [15:0] reg_in, reg_out;
    logic        ba_zero, c_out, seq_busy, seq_done;
    logic [31:0] c_sign_extended;

    int tests;
    int fails;

    reg_select_sequencer dut (
        .clock           (clock),
        .clear_n         (clear_n),
        .ir_load         (ir_load),
        .instruction     (instruction),
        .gra             (gra),
        .grb             (grb),
        .grc             (grc),
        .rin             (rin),
        .rout            (rout),
        .baout           (baout),
        .seq_start       (seq_start),
        .seq_use_imm     (seq_use_imm),
        .reg_in          (reg_in),
        .reg_out         (reg_out),
        .ba_zero         (ba_zero),
        .c_out           (c_out),
        .c_sign_extended (c_sign_extended),
        .seq_busy        (seq_busy),
        .seq_done        (seq_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  sel;      // {gra, grb, grc, rin, rout, baout}
        logic [15:0] exp_in;
        logic [15:0] exp_out;
        logic        exp_ba;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [31:0] mk(input logic [3:0] ra,
                                       input logic [3:0] rb,
                                       input logic [3:0] rc);
        return {5'd0, ra, rb, rc, 15'd0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ir_load = 0; instruction = '0;
        {gra, grb, grc, rin, rout, baout} = '0;
        seq_start = 0; seq_use_imm = 0;
    endtask

    task automatic load_ir(input logic [31:0] v);
        ir_load = 1; instruction = v;
        step();
        ir_load = 0; instruction = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();

        vecs[0] = '{mk(5,3,9), 6'b100100, 16'h0020, 16'h0000, 1'b0};
        vecs[1] = '{mk(5,3,9), 6'b010010, 16'h0000, 16'h0008, 1'b0};
        vecs[2] = '{mk(5,3,9), 6'b001010, 16'h0000, 16'h0200, 1'b0};
        vecs[3] = '{mk(5,3,9), 6'b000110, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{mk(5,3,9), 6'b111100, 16'h0020, 16'h0000, 1'b0};
        vecs[5] = '{mk(0,7,2), 6'b110001, 16'h0000, 16'h0000, 1'b1};
        vecs[6] = '{mk(0,7,2), 6'b010001, 16'h0000, 16'h0080, 1'b0};
        vecs[7] = '{mk(0,7,2), 6'b001110, 16'h0004, 16'h0000, 1'b0};
        vecs[8] = '{mk(0,7,2), 6'b100010, 16'h0000, 16'h0001, 1'b0};

        clear_n = 0;
        #12;
        chk("rst_reg_in", reg_in, 0);
        chk("rst_reg_out", reg_out, 0);
        chk("rst_busy", seq_busy, 0);
        chk("rst_csx", c_sign_extended, 0);
        @(negedge clock);
        clear_n = 1;
        step();

        // Manual select table.
        for (int i = 0; i < 9; i++) begin
            load_ir(vecs[i].instr);
            {gra, grb, grc, rin, rout, baout} = vecs[i].sel;
            step();
            chk($sformatf("v%0d_in", i), reg_in, vecs[i].exp_in);
            chk($sformatf("v%0d_out", i), reg_out, vecs[i].exp_out);
            chk($sformatf("v%0d_ba", i), ba_zero, vecs[i].exp_ba);
            {gra, grb, grc, rin, rout, baout} = '0;
            step();
            chk($sformatf("v%0d_in_hold", i), reg_in, 0);
            chk($sformatf("v%0d_out_hold", i), reg_out, 0);
        end

        // Register sequence; manual gra/rout at start must be dropped.
        load_ir(mk(1,2,4));
        seq_start = 1; gra = 1; rout = 1;
        step();
        seq_start = 0;
        chk("seq_b_out", reg_out, 16'h0004);
        chk("seq_b_in", reg_in, 0);
        chk("seq_b_busy", seq_busy, 1);
        chk("seq_b_done", seq_done, 0);
        ir_load = 1; instruction = 32'hFFFF_FFFF;
        step();
        chk("seq_c_out", reg_out, 16'h0010);
        chk("seq_c_cout", c_out, 0);
        chk("seq_c_busy", seq_busy, 1);
        step();
        ir_load = 0; instruction = '0;
        gra = 0; rout = 0;
        chk("seq_a_in", reg_in, 16'h0002);
        chk("seq_a_out", reg_out, 0);
        chk("seq_a_done", seq_done, 1);
        chk("seq_a_busy", seq_busy, 1);
        step();
        chk("seq_end_busy", seq_busy, 0);
        chk("seq_end_done", seq_done, 0);
        chk("seq_end_in", reg_in, 0);
        chk("seq_ir_held", c_sign_extended, 32'h0002_0000);

        // Immediate sequence, IR loaded on the same edge as seq_start.
        ir_load = 1; instruction = 32'h0187_FFFF;
        seq_start = 1; seq_use_imm = 1;
        step();
        idle_inputs();
        chk("imm_b_out", reg_out, 16'h0001);
        chk("imm_csx_neg", c_sign_extended, 32'hFFFF_FFFF);
        step();
        chk("imm_c_cout", c_out, 1);
        chk("imm_c_out", reg_out, 0);
        step();
        chk("imm_a_in", reg_in, 16'h0008);
        chk("imm_a_cout", c_out, 0);
        chk("imm_a_done", seq_done, 1);
        step();
        load_ir(32'h0003_FFFF);
        chk("imm_csx_pos", c_sign_extended, 32'h0003_FFFF);

        // Back-to-back restart with seq_start held; rout during busy ignored.
        load_ir(mk(1,2,4));
        seq_start = 1;
        step();
        chk("b2b_1_out", reg_out, 16'h0004);
        grb = 1; rout = 1;
        step();
        chk("b2b_c_out", reg_out, 16'h0010);
        step();
        chk("b2b_a_out", reg_out, 0);
        chk("b2b_a_in", reg_in, 16'h0002);
        grb = 0; rout = 0;
        step();
        chk("b2b_gap_busy", seq_busy, 0);
        chk("b2b_gap_out", reg_out, 0);
        step();
        seq_start = 0;
        chk("b2b_2_busy", seq_busy, 1);
        chk("b2b_2_out", reg_out, 16'h0004);

        // Reset asserted during STEP_C.
        step();
        chk("mid_c_out", reg_out, 16'h0010);
        #2;
        clear_n = 0;
        #1;
        chk("mid_rst_out", reg_out, 0);
        chk("mid_rst_busy", seq_busy, 0);
        chk("mid_rst_csx", c_sign_extended, 0);
        @(negedge clock);
        clear_n = 1;
        step();
        chk("mid_post_busy", seq_busy, 0);
        chk("mid_post_done", seq_done, 0);
        chk("mid_post_in", reg_in, 0);
        step();
        chk("mid_post2_done", seq_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
